// File: rtl/dl_accumulate_with_sticky_flags_pkg.sv
// rtl/dl_accumulate_with_sticky_flags_pkg.sv - shared constants for the sticky-flag accumulator
//
// Purpose:
//   Holds the FSM state encoding and the default datapath/counter widths that
//   are shared by the accumulator top and its adder core.
//   The states are plain 2-bit localparams rather than an enum, so that older
//   tools and existing compare logic can use the same literal values.
//
// Contents:
//   ST_IDLE, ST_ACCUM, ST_DONE   FSM state codes (2 bits)
//   N_DEFAULT                    default operand/sum width
//   CNT_W_DEFAULT                default beat-counter width

package dl_accumulate_with_sticky_flags_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_ACCUM = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd2;

    localparam int N_DEFAULT     = 32;
    localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/dl_accumulate_with_sticky_flags_adder_core.sv
// rtl/dl_accumulate_with_sticky_flags_adder_core.sv - combinational n-bit adder with carryout and signed overflow
//
// Purpose:
//   Adds two n-bit two's-complement operands plus a carry-in. The sum and the
//   carryout come from a single n+1-bit add. Signed overflow is taken from the
//   carry into the sign bit, recovered as carryout ^ X[msb] ^ Y[msb] ^ S[msb].
//
// Ports:
//   X         in   n   first operand (running accumulator)
//   Y         in   n   second operand (incoming beat)
//   carryin   in   1   carry-in
//   S         out  n   sum modulo 2**n
//   carryout  out  1   unsigned carry out of bit n-1
//   overflow  out  1   signed overflow of the add

module dl_adder_core
    import dl_accumulate_with_sticky_flags_pkg::*;
#(
    parameter int n = N_DEFAULT
) (
    input  logic [n-1:0] X,
    input  logic [n-1:0] Y,
    input  logic         carryin,
    output logic [n-1:0] S,
    output logic         carryout,
    output logic         overflow
);

    logic [n:0] full_sum;

    // Widen every term to n+1 bits so the carry lands in the top bit.
    assign full_sum = {1'b0, X} + {1'b0, Y} + {{n{1'b0}}, carryin};

    assign S        = full_sum[n-1:0];
    assign carryout = full_sum[n];

    // Carry into the MSB is X^Y^S at that bit; XOR with the carry out of the
    // MSB gives signed overflow.
    assign overflow = full_sum[n] ^ X[n-1] ^ Y[n-1] ^ full_sum[n-1];

endmodule

// File: rtl/dl_accumulate_with_sticky_flags.sv
// rtl/dl_accumulate_with_sticky_flags.sv - burst accumulator with sticky carry/overflow flags
//
// Purpose:
//   Accepts a burst of operands on a valid/ready input (terminated by in_last).
//   Each operand plus its carry-in is added into a running n-bit sum. Carryout
//   and signed overflow are ORed into sticky flags, and accepted beats are
//   counted (the count saturates). When the last beat has been taken, the
//   result is held on a valid/ready output until it is consumed. The block
//   then returns to IDLE, and the sum, flags and count are cleared on that
//   same edge.
//
// Ports:
//   clock         in   1      rising-edge clock
//   reset         in   1      asynchronous, active-high; clears all state
//   in_valid      in   1      operand beat present
//   in_ready      out  1      block can accept a beat this cycle
//   in_data       in   n      operand, two's complement
//   in_cin        in   1      carry-in added with this beat
//   in_last       in   1      final beat of burst (qualified by in_valid)
//   out_valid     out  1      burst result held
//   out_ready     in   1      consumer takes result
//   out_sum       out  n      accumulated sum, modulo 2**n
//   out_carry     out  1      OR of carryout over all beats of burst
//   out_overflow  out  1      OR of signed overflow over all beats of burst
//   out_count     out  CNT_W  beats accepted in burst (saturating)

module dl_accumulate_with_sticky_flags
    import dl_accumulate_with_sticky_flags_pkg::*;
#(
    parameter int n     = N_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [n-1:0]     in_data,
    input  logic             in_cin,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [n-1:0]     out_sum,
    output logic             out_carry,
    output logic             out_overflow,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [STATE_W-1:0] state;
    logic [n-1:0]       acc;
    logic               carry_sticky;
    logic               ovfl_sticky;
    logic [CNT_W-1:0]   count;

    logic [n-1:0]       add_sum;
    logic               add_carry;
    logic               add_ovfl;
    logic               beat;
    logic [CNT_W-1:0]   count_next;

    dl_adder_core #(
        .n (n)
    ) u_adder_core (
        .X        (acc),
        .Y        (in_data),
        .carryin  (in_cin),
        .S        (add_sum),
        .carryout (add_carry),
        .overflow (add_ovfl)
    );

    // While a result is held (DONE), the input is stalled. This gives the
    // single bubble cycle per burst, even when out_ready is already high.
    assign in_ready  = (state != ST_DONE);
    assign out_valid = (state == ST_DONE);
    assign beat      = in_valid && in_ready;

    // Counter holds at all-ones instead of wrapping; the sum keeps going.
    assign count_next = (count == CNT_MAX) ? count : count + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            acc          <= '0;
            carry_sticky <= 1'b0;
            ovfl_sticky  <= 1'b0;
            count        <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ACCUM: begin
                    if (beat) begin
                        acc          <= add_sum;
                        carry_sticky <= carry_sticky | add_carry;
                        ovfl_sticky  <= ovfl_sticky | add_ovfl;
                        count        <= count_next;
                        state        <= in_last ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    // Clear on the hand-off edge so IDLE always starts from zero.
                    if (out_ready) begin
                        state        <= ST_IDLE;
                        acc          <= '0;
                        carry_sticky <= 1'b0;
                        ovfl_sticky  <= 1'b0;
                        count        <= '0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    acc          <= '0;
                    carry_sticky <= 1'b0;
                    ovfl_sticky  <= 1'b0;
                    count        <= '0;
                end
            endcase
        end
    end

    // Outputs mirror the internal registers at all times; out_valid qualifies them.
    assign out_sum      = acc;
    assign out_carry    = carry_sticky;
    assign out_overflow = ovfl_sticky;
    assign out_count    = count;

endmodule

// File: tb/tb_dl_accumulate_with_sticky_flags.sv
// tb/tb_dl_accumulate_with_sticky_flags.sv - directed self-checking bench for the sticky-flag accumulator

module tb_dl_accumulate_with_sticky_flags;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          in_cin;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_sum;
    logic          out_carry;
    logic          out_overflow;
    logic [CW-1:0] out_count;

    int total;
    int passed;

    dl_accumulate_with_sticky_flags #(
        .n     (N),
        .CNT_W (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_cin       (in_cin),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_count    (out_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Presents one beat, lets one rising edge take it, returns 1 time unit later.
    task automatic drive(input logic [N-1:0] d, input logic cin, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_cin   = cin;
        in_last  = last;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_cin   = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [N-1:0] sum, input logic c,
                              input logic v, input logic [CW-1:0] cnt);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_sum"}, {24'd0, out_sum}, {24'd0, sum});
        chk({tag, "_carry"}, {31'd0, out_carry}, {31'd0, c});
        chk({tag, "_ovf"}, {31'd0, out_overflow}, {31'd0, v});
        chk({tag, "_count"}, {28'd0, out_count}, {28'd0, cnt});
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_sum"}, {24'd0, out_sum}, 32'd0);
        chk({tag, "_flags"}, {30'd0, out_carry, out_overflow}, 32'd0);
        chk({tag, "_count"}, {28'd0, out_count}, 32'd0);
    endtask

    // Hands the held result off with out_ready for one edge.
    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk_cleared(tag);
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cin    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_cleared("reset_hold");
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk_cleared("reset_state");

        // 1: simple burst, result visible right after the 3rd beat
        drive(8'h10, 1'b0, 1'b0);
        chk("t1_beat1_sum", {24'd0, out_sum}, 32'h10);
        chk("t1_beat1_valid", {31'd0, out_valid}, 32'd0);
        drive(8'h20, 1'b0, 1'b0);
        out_ready = 1'b1;
        drive(8'h30, 1'b0, 1'b1);
        chk_result("t1", 8'h60, 1'b0, 1'b0, 4'd3);
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk_cleared("t1_release");

        // 2: signed overflow only, then carry only
        drive(8'h7F, 1'b0, 1'b0);
        drive(8'h01, 1'b0, 1'b1);
        chk_result("t2a", 8'h80, 1'b0, 1'b1, 4'd2);
        release_result("t2a_release");
        drive(8'hFF, 1'b0, 1'b0);
        drive(8'h01, 1'b0, 1'b1);
        chk_result("t2b", 8'h00, 1'b1, 1'b0, 4'd2);
        release_result("t2b_release");

        // 3: overflow stays sticky after the sum returns into range
        drive(8'h7F, 1'b0, 1'b0);
        drive(8'h01, 1'b0, 1'b0);
        drive(8'hFF, 1'b0, 1'b1);
        chk_result("t3", 8'h7F, 1'b1, 1'b1, 4'd3);
        release_result("t3_release");

        // 4: back-pressure in DONE while the producer keeps offering a beat
        drive(8'h10, 1'b0, 1'b0);
        drive(8'h05, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chk_result($sformatf("t4_stall%0d", i), 8'h15, 1'b0, 1'b0, 4'd2);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk_cleared("t4_handoff");
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_result("t4_next", 8'h55, 1'b0, 1'b0, 4'd1);
        release_result("t4_release");

        // 5: counter saturation, sum keeps accumulating
        for (int i = 0; i < 18; i++) drive(8'h01, 1'b0, (i == 17));
        chk_result("t5_sat", 8'h12, 1'b0, 1'b0, 4'd15);
        release_result("t5_release");
        drive(8'h05, 1'b1, 1'b1);
        chk_result("t5_single", 8'h06, 1'b0, 1'b0, 4'd1);
        release_result("t5_single_release");

        // 6: asynchronous reset in mid-burst, between clock edges
        drive(8'h11, 1'b0, 1'b0);
        drive(8'h22, 1'b0, 1'b0);
        chk("t6_pre_sum", {24'd0, out_sum}, 32'h33);
        #2;
        reset = 1'b1;
        #1;
        chk_cleared("t6_async");
        #2;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk_cleared("t6_after");
        drive(8'h03, 1'b0, 1'b1);
        chk_result("t6_next", 8'h03, 1'b0, 1'b0, 4'd1);
        release_result("t6_release");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
